// File: rtl/pprr_arbiter_lock.sv
// Round-robin arbiter with registered one-hot grant, multi-cycle grant lock and a
// MAX_HOLD starvation guard; the winner comes from a cyclic Kogge-Stone prefix network.
module pprr_arbiter_lock #(
    parameter int NUM_REQ  = 8,
    parameter int MAX_HOLD = 16,
    parameter int IDX_W    = $clog2(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_en,
    input  logic               i_last,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_ag,
    output logic               o_timeout
);

    localparam int LEVELS = $clog2(NUM_REQ);
    localparam int HCNT_W = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t              state;
    logic [NUM_REQ-1:0]  ptr;
    logic [HCNT_W-1:0]   hcnt;

    logic                rel_last;
    logic                rel_abort;
    logic                rel_tmo;
    logic                release_now;
    logic                arb_now;
    logic [NUM_REQ-1:0]  rot_grant;
    logic [NUM_REQ-1:0]  eff_ptr;
    logic [NUM_REQ-1:0]  winner;
    logic [IDX_W-1:0]    winner_idx;

    assign rel_last    = i_en & i_last;
    assign rel_abort   = ~|(i_req & o_grant);
    assign rel_tmo     = (hcnt == HCNT_W'(MAX_HOLD));
    assign release_now = (state == LOCKED) & (rel_last | rel_abort | rel_tmo);
    assign arb_now     = (state == IDLE) | release_now;
    assign rot_grant   = {o_grant[NUM_REQ-2:0], o_grant[NUM_REQ-1]};
    assign eff_ptr     = release_now ? rot_grant : ptr;

    // Node i of level L summarises the 2^L requesters just below i (cyclically):
    // a = a request was found before reaching the pointer, b = the pointer was not met yet.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        logic [NUM_REQ-1:0] a;
        logic [NUM_REQ-1:0] b;
        if (l == 0) begin : g_init
            assign a = {i_req[NUM_REQ-2:0], i_req[NUM_REQ-1]};
            assign b = ~{eff_ptr[NUM_REQ-2:0], eff_ptr[NUM_REQ-1]};
        end else begin : g_comb
            for (genvar i = 0; i < NUM_REQ; i++) begin : g_node
                localparam int J = (i + NUM_REQ - ((1 << (l - 1)) % NUM_REQ)) % NUM_REQ;
                assign a[i] = g_lvl[l-1].a[i] | (g_lvl[l-1].b[i] & g_lvl[l-1].a[J]);
                assign b[i] = g_lvl[l-1].b[i] & g_lvl[l-1].b[J];
            end
        end
    end

    // The pointer position itself always has top priority, so it ignores the scan result.
    assign winner = i_req & (eff_ptr | ~g_lvl[LEVELS].a);

    always_comb begin
        winner_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (winner[k]) winner_idx = IDX_W'(k);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= IDLE;
            ptr         <= NUM_REQ'(1);
            hcnt        <= '0;
            o_grant     <= '0;
            o_grant_idx <= '0;
            o_ag        <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            o_timeout <= release_now & rel_tmo & ~rel_last & ~rel_abort;
            if (release_now) ptr <= rot_grant;
            if (arb_now) begin
                if (i_en && (|i_req)) begin
                    state       <= LOCKED;
                    o_grant     <= winner;
                    o_grant_idx <= winner_idx;
                    o_ag        <= 1'b1;
                    hcnt        <= HCNT_W'(1);
                end else begin
                    state       <= IDLE;
                    o_grant     <= '0;
                    o_grant_idx <= '0;
                    o_ag        <= 1'b0;
                    hcnt        <= '0;
                end
            end else if (hcnt != HCNT_W'(MAX_HOLD)) begin
                hcnt <= hcnt + HCNT_W'(1);
            end
        end
    end

endmodule
